// File: rtl/pio_link_pkg.sv
// Shared types for the PIO byte link: software command codes and download states.
package pio_link_pkg;

    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_START = 2'b01,
        CMD_ACK   = 2'b10,
        CMD_ABORT = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PRESENT,
        WAIT_REL
    } dl_state_e;

endpackage

// File: rtl/pio_byte_link_ctrl_if.sv
// PIO bank, download FIFO and upload stream signals of the byte link.
// The slave side is the controller; the master side is software plus board logic.
interface pio_byte_link_ctrl_if #(
    parameter int DW = pio_link_pkg::DW_DEF
);
    logic [1:0]    pio_outsignal;
    logic [DW-1:0] pio_curbyteout;
    logic          pio_load;
    logic          pio_readytodownload;
    logic          pio_instrobe;
    logic [DW-1:0] pio_curbytein;
    logic          pio_empty;
    logic          dl_fifo_empty;
    logic [DW-1:0] dl_fifo_rdata;
    logic          dl_fifo_rd;
    logic          ul_valid;
    logic [DW-1:0] ul_data;
    logic          ul_ready;
    logic          err_timeout;
    logic          err_overflow;

    modport slave (
        input  pio_outsignal, pio_curbyteout, pio_load,
        input  dl_fifo_empty, dl_fifo_rdata, ul_ready,
        output pio_readytodownload, pio_instrobe, pio_curbytein, pio_empty,
        output dl_fifo_rd, ul_valid, ul_data, err_timeout, err_overflow
    );

    modport master (
        output pio_outsignal, pio_curbyteout, pio_load,
        output dl_fifo_empty, dl_fifo_rdata, ul_ready,
        input  pio_readytodownload, pio_instrobe, pio_curbytein, pio_empty,
        input  dl_fifo_rd, ul_valid, ul_data, err_timeout, err_overflow
    );
endinterface

// File: rtl/pio_link_ul_slot.sv
// Upload path: rising-edge detect on the software load strobe feeding a single
// valid/ready holding slot, with a sticky flag for bytes that found it full.
module pio_link_ul_slot #(
    parameter int DW = pio_link_pkg::DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_byte,
    input  logic          i_ul_ready,
    input  logic          i_clr,
    output logic          o_ul_valid,
    output logic [DW-1:0] o_ul_data,
    output logic          o_overflow
);

    logic          r_load_q;
    logic          r_ul_valid;
    logic [DW-1:0] r_ul_data;
    logic          r_overflow;
    logic          w_edge;
    logic          w_slot_free;

    assign w_edge      = i_load & ~r_load_q;
    // A byte leaving this cycle frees the slot for a same-cycle arrival.
    assign w_slot_free = ~r_ul_valid | i_ul_ready;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data register is reset too, so ul_data reads 0 after reset.
            r_load_q   <= 1'b0;
            r_ul_valid <= 1'b0;
            r_ul_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_load_q <= i_load;

            if (w_edge && w_slot_free) begin
                r_ul_data  <= i_byte;
                r_ul_valid <= 1'b1;
            end else if (!w_edge && r_ul_valid && i_ul_ready) begin
                r_ul_valid <= 1'b0;
            end

            if (i_clr) begin
                r_overflow <= 1'b0;
            end else if (w_edge && !w_slot_free) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_ul_valid = r_ul_valid;
    assign o_ul_data  = r_ul_data;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/pio_byte_link_ctrl.sv
// Byte sequencer between the Nios PIO bank and the board byte streams: download
// FSM with ACK timeout, plus the upload slot.
module pio_byte_link_ctrl
    import pio_link_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    pio_byte_link_ctrl_if.slave bus
);

    localparam bit             TO_EN    = (TIMEOUT_CYC != 0);
    localparam int             CW       = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TO_EN ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CW-1:0]  CNT_SAT  = '1;

    dl_state_e     r_state;
    dl_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_curbytein;
    logic          r_err_timeout;
    cmd_e          w_cmd;
    logic          w_abort;
    logic          w_dl_rd;
    logic          w_to_hit;

    assign w_cmd   = cmd_e'(bus.pio_outsignal);
    assign w_abort = (w_cmd == CMD_ABORT);

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        w_state_nxt = r_state;
        w_dl_rd     = 1'b0;
        w_to_hit    = 1'b0;

        if (w_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd == CMD_START) w_state_nxt = ARMED;
                end
                ARMED: begin
                    if (!bus.dl_fifo_empty) begin
                        w_dl_rd     = 1'b1;
                        w_state_nxt = PRESENT;
                    end
                end
                PRESENT: begin
                    // ACK arriving on the last allowed cycle still wins.
                    if (w_cmd == CMD_ACK) begin
                        w_state_nxt = WAIT_REL;
                    end else if (TO_EN && r_cnt == CNT_LAST) begin
                        w_to_hit    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                WAIT_REL: begin
                    if (w_cmd != CMD_ACK) w_state_nxt = ARMED;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_curbytein   <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_dl_rd) r_curbytein <= bus.dl_fifo_rdata;

            // Counts completed PRESENT cycles; restarts on every fresh byte.
            if (r_state == PRESENT && w_state_nxt == PRESENT) begin
                if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (w_abort) begin
                r_err_timeout <= 1'b0;
            end else if (w_to_hit) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign bus.pio_readytodownload = (r_state != IDLE);
    assign bus.pio_instrobe        = (r_state == PRESENT);
    assign bus.pio_curbytein       = r_curbytein;
    assign bus.pio_empty           = bus.dl_fifo_empty & (r_state != PRESENT);
    assign bus.dl_fifo_rd          = w_dl_rd;
    assign bus.err_timeout         = r_err_timeout;

    pio_link_ul_slot #(
        .DW (DW)
    ) u_ul_slot (
        .clk        (clk_clk),
        .rst_n      (reset_reset_n),
        .i_load     (bus.pio_load),
        .i_byte     (bus.pio_curbyteout),
        .i_ul_ready (bus.ul_ready),
        .i_clr      (w_abort),
        .o_ul_valid (bus.ul_valid),
        .o_ul_data  (bus.ul_data),
        .o_overflow (bus.err_overflow)
    );

endmodule
